// File: rtl/race_timer_board.sv
// race_timer_board: run timer with start/pause/finish control and a sorted leaderboard of the DEPTH lowest finish times.
// Ports: clk, reset_n (sync, active low); start/pause/gameover/clear_scores from the game FSM;
// rd_idx selects a leaderboard entry for the registered rd_data read port; cur_time/running/overflow
// report the live run; best_time is entry 0; last_rank/rank_valid/new_record report the last finished run.
module race_timer_board #(
  parameter int CLK_FREQ = 100000000,
  parameter int TICK_RATE = 10,
  parameter int TW = 16,
  parameter int DEPTH = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          pause,
  input  logic          gameover,
  input  logic          clear_scores,
  input  logic [IW-1:0] rd_idx,
  output logic [TW-1:0] cur_time,
  output logic          running,
  output logic          overflow,
  output logic [TW-1:0] best_time,
  output logic [TW-1:0] rd_data,
  output logic [IW:0]   last_rank,
  output logic          rank_valid,
  output logic          new_record
);
  localparam int TICK_DIV = CLK_FREQ / TICK_RATE;
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] EMPTY = '1;
  localparam logic [TW-1:0] MAX = EMPTY - 1'b1;
  localparam logic [TW-1:0] PRE = MAX - 1'b1;
  localparam logic [IW:0] NO_RANK = (IW+1)'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  typedef enum logic [1:0] {IDLE, RUNNING, FINISH, DONE} state_t;
  state_t state, state_nx;
  logic gameover_q, go_edge, tick;
  logic [DW-1:0] div;
  logic [TW-1:0] entries [DEPTH];
  logic [TW-1:0] base [DEPTH];
  logic [TW-1:0] ins [DEPTH];
  logic [IW:0] cnt, rank;
  assign go_edge = gameover & ~gameover_q;
  assign tick = state == RUNNING && !pause && div == DIV_LAST;
  assign running = state == RUNNING;
  assign best_time = entries[0];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUNNING : IDLE;
      RUNNING: state_nx = start ? RUNNING : go_edge ? FINISH : RUNNING;
      FINISH:  state_nx = DONE;
      DONE:    state_nx = start ? RUNNING : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // A clear coinciding with the insertion is applied first, so the run is ranked against an empty board.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      base[i] = clear_scores ? EMPTY : entries[i];
      cnt = cnt + (IW+1)'(base[i] <= cur_time);
    end
    rank = overflow ? NO_RANK : cnt;
    for (int i = 0; i < DEPTH; i++)
      ins[i] = i < int'(rank) ? base[i] : i == int'(rank) ? cur_time : base[i == 0 ? 0 : i - 1];
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      gameover_q <= 1'b0;
      div <= '0;
      cur_time <= '0;
      overflow <= 1'b0;
      entries <= '{default: EMPTY};
      last_rank <= NO_RANK;
      rank_valid <= 1'b0;
      new_record <= 1'b0;
      rd_data <= EMPTY;
    end else begin
      state <= state_nx;
      gameover_q <= gameover;
      if (start && state != FINISH) begin
        div <= '0;
        cur_time <= '0;
        overflow <= 1'b0;
      end else if (state == RUNNING && !pause) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick && cur_time != MAX) cur_time <= cur_time + 1'b1;
        if (tick && cur_time == PRE) overflow <= 1'b1;
      end
      if (state == FINISH) entries <= ins;
      else if (clear_scores) entries <= '{default: EMPTY};
      last_rank <= state == FINISH ? rank : clear_scores ? NO_RANK : last_rank;
      rank_valid <= state == FINISH;
      new_record <= state == FINISH && rank == '0;
      rd_data <= int'(rd_idx) < DEPTH ? entries[rd_idx] : EMPTY;
    end
  end
endmodule

// File: tb/tb_race_timer_board.sv
// tb_race_timer_board: scoreboard bench for race_timer_board with TICK_DIV=10, TW=8, DEPTH=4.
module tb_race_timer_board;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, pause = 1'b0, gameover = 1'b0, clear_scores = 1'b0;
  logic [1:0] rd_idx = '0;
  logic [7:0] cur_time, best_time, rd_data;
  logic running, overflow, rank_valid, new_record;
  logic [2:0] last_rank;
  typedef struct {int rank; int t; bit rec; bit ovf;} exp_t;
  exp_t sb[$];
  int model_b[4];
  int n_cmp = 0, n_bad = 0;
  race_timer_board #(.CLK_FREQ(100), .TICK_RATE(10), .TW(8), .DEPTH(4), .IW(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .gameover(gameover),
    .clear_scores(clear_scores), .rd_idx(rd_idx), .cur_time(cur_time), .running(running),
    .overflow(overflow), .best_time(best_time), .rd_data(rd_data), .last_rank(last_rank),
    .rank_valid(rank_valid), .new_record(new_record)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask
  task automatic check_board();
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      @(posedge clk); #1;
      check($sformatf("rd_data[%0d]", i), int'(rd_data), model_b[i]);
    end
    check("best_time", int'(best_time), model_b[0]);
  endtask
  // n = RUNNING edges up to and including the gameover edge; edges p_at+1..p_at+p_len are paused.
  task automatic run(input int n, input int p_at, input int p_len, input bit pre_go, input bit clr);
    int cnt, t, rk, w;
    bit ovf;
    exp_t e;
    cnt = 0;
    gameover = pre_go;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < n; k++) begin
      pause = k > p_at && k <= p_at + p_len;
      if (pre_go && k == n - 1) gameover = 1'b0;
      if (!pause) cnt++;
      @(posedge clk); #1;
    end
    check("running_before_end", int'(running), 1);
    pause = 1'b0;
    cnt++;
    t = cnt / 10;
    ovf = t >= 254;
    if (t > 254) t = 254;
    if (clr) for (int i = 0; i < 4; i++) model_b[i] = 255;
    rk = 0;
    for (int i = 0; i < 4; i++) if (model_b[i] <= t) rk++;
    if (ovf) rk = 4;
    if (rk < 4) begin
      for (int i = 3; i > rk; i--) model_b[i] = model_b[i-1];
      model_b[rk] = t;
    end
    sb.push_back('{rk, t, rk == 0, ovf});
    gameover = 1'b1;
    @(posedge clk); #1;
    check("running_in_finish", int'(running), 0);
    clear_scores = clr;
    @(posedge clk); #1;
    clear_scores = 1'b0;
    w = 0;
    while (!rank_valid && w < 4) begin
      @(posedge clk); #1;
      w++;
    end
    if (!rank_valid) check("rank_valid_timeout", 0, 1);
    else begin
      e = sb.pop_front();
      check("last_rank", int'(last_rank), e.rank);
      check("new_record", int'(new_record), int'(e.rec));
      check("cur_time", int'(cur_time), e.t);
      check("overflow", int'(overflow), int'(e.ovf));
      gameover = 1'b0;
      @(posedge clk); #1;
      check("rank_valid_pulse", int'(rank_valid), 0);
      check("new_record_pulse", int'(new_record), 0);
      check("cur_time_frozen", int'(cur_time), e.t);
    end
    gameover = 1'b0;
    check_board();
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) model_b[i] = 255;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cur_time", int'(cur_time), 0);
    check("rst_running", int'(running), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_last_rank", int'(last_rank), 4);
    check("rst_rank_valid", int'(rank_valid), 0);
    check("rst_new_record", int'(new_record), 0);
    check("rst_rd_data", int'(rd_data), 255);
    check("rst_best_time", int'(best_time), 255);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run(35, 0, 0, 0, 0);
    clear_scores = 1'b1;
    @(posedge clk); #1;
    clear_scores = 1'b0;
    for (int i = 0; i < 4; i++) model_b[i] = 255;
    check("clear_last_rank", int'(last_rank), 4);
    run(53, 0, 0, 0, 0);
    run(23, 0, 0, 0, 0);
    run(73, 0, 0, 0, 0);
    run(23, 0, 0, 0, 0);
    run(93, 0, 0, 0, 0);
    run(73, 4, 23, 0, 0);
    run(3000, 0, 0, 0, 0);
    run(20, 0, 0, 1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("midrun_cur_time", int'(cur_time), 2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("abort_cur_time", int'(cur_time), 0);
    check("abort_running", int'(running), 0);
    check("abort_last_rank", int'(last_rank), 4);
    for (int i = 0; i < 4; i++) model_b[i] = 255;
    check_board();
    run(15, 0, 0, 0, 0);
    run(25, 0, 0, 0, 0);
    run(35, 0, 0, 0, 0);
    run(45, 0, 0, 0, 0);
    run(95, 0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
